// File: rtl/digiota_trim_cal.sv
// digiota_trim_cal: per-channel SAR offset-trim calibration for the OTA channels.
// Channels are calibrated one after another. Each trial code is held for SETTLE
// cycles and then judged in a single DECIDE cycle from the synchronised comparator.
module digiota_trim_cal #(
    parameter int CHANNELS = 2,
    parameter int TRIM_W   = 5,
    parameter int SETTLE   = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [CHANNELS-1:0]        cmp,
    output logic [CHANNELS*TRIM_W-1:0] trim,
    output logic [CHANNELS-1:0]        cal_en,
    output logic                       busy,
    output logic                       done,
    output logic [CHANNELS-1:0]        rail,
    output logic [2:0]                 ch_idx
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_DECIDE = 2'd2;

    localparam int BIT_W = $clog2(TRIM_W);
    localparam int CNT_W = $clog2(SETTLE);

    localparam logic [TRIM_W-1:0] MID      = {1'b1, {(TRIM_W-1){1'b0}}};
    localparam logic [BIT_W-1:0]  BIT_TOP  = BIT_W'(TRIM_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [2:0]        CH_LAST  = 3'(CHANNELS - 1);

    logic [1:0]                 state_q,  state_d;
    logic [CNT_W-1:0]           cnt_q,    cnt_d;
    logic [BIT_W-1:0]           bit_q,    bit_d;
    logic [2:0]                 ch_q,     ch_d;
    logic [CHANNELS*TRIM_W-1:0] trim_q,   trim_d;
    logic [CHANNELS-1:0]        cal_en_q, cal_en_d;
    logic                       busy_q,   busy_d;
    logic                       done_q,   done_d;
    logic [CHANNELS-1:0]        rail_q,   rail_d;
    logic [CHANNELS-1:0]        sync1_q,  sync1_d;
    logic [CHANNELS-1:0]        sync2_q,  sync2_d;

    logic [TRIM_W-1:0] cur_code;
    logic [TRIM_W-1:0] new_code;
    logic              cur_cmp;
    logic              new_rail;
    logic              wr_cur;
    logic [TRIM_W-1:0] wr_val;
    logic              wr_rail;
    logic              rail_val;
    logic              ld_next;

    // Next-state logic: sequencer decisions, then one write-back pass over the channels
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        ch_d     = ch_q;
        trim_d   = trim_q;
        cal_en_d = cal_en_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rail_d   = rail_q;
        sync1_d  = cmp;
        sync2_d  = sync1_q;

        cur_code = '0;
        cur_cmp  = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch_q == 3'(c)) begin
                cur_code = trim_q[c*TRIM_W +: TRIM_W];
                cur_cmp  = sync2_q[c];
            end
        end

        // Comparator high means the trial code overshot: drop the bit under test
        new_code = cur_code;
        if (cur_cmp) begin
            new_code[bit_q] = 1'b0;
        end
        if (bit_q != '0) begin
            new_code[bit_q - 1'b1] = 1'b1;
        end
        new_rail = (new_code == '0) || (new_code == '1);

        wr_cur   = 1'b0;
        wr_val   = MID;
        wr_rail  = 1'b0;
        rail_val = 1'b0;
        ld_next  = 1'b0;

        if (busy_q && abort) begin
            // Channel in progress goes back to midscale; finished channels keep their codes
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            cal_en_d = '0;
            ch_d     = '0;
            cnt_d    = '0;
            bit_d    = BIT_TOP;
            wr_cur   = 1'b1;
            wr_val   = MID;
            wr_rail  = 1'b1;
            rail_val = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // ch_q is always 0 in IDLE, so the current-channel write targets channel 0
                    if (start) begin
                        state_d  = S_SETTLE;
                        ch_d     = '0;
                        bit_d    = BIT_TOP;
                        cnt_d    = '0;
                        wr_cur   = 1'b1;
                        wr_val   = MID;
                        wr_rail  = 1'b1;
                        rail_val = 1'b0;
                        cal_en_d = CHANNELS'(1);
                        busy_d   = 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DECIDE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DECIDE: begin
                    wr_cur = 1'b1;
                    wr_val = new_code;
                    cnt_d  = '0;
                    if (bit_q != '0) begin
                        bit_d   = bit_q - 1'b1;
                        state_d = S_SETTLE;
                    end else begin
                        wr_rail  = 1'b1;
                        rail_val = new_rail;
                        bit_d    = BIT_TOP;
                        if (ch_q != CH_LAST) begin
                            ch_d     = ch_q + 3'd1;
                            ld_next  = 1'b1;
                            cal_en_d = cal_en_q << 1;
                            state_d  = S_SETTLE;
                        end else begin
                            ch_d     = '0;
                            cal_en_d = '0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch_q == 3'(c)) begin
                if (wr_cur) begin
                    trim_d[c*TRIM_W +: TRIM_W] = wr_val;
                end
                if (wr_rail) begin
                    rail_d[c] = rail_val;
                end
            end
            if (ld_next && ((ch_q + 3'd1) == 3'(c))) begin
                trim_d[c*TRIM_W +: TRIM_W] = MID;
                rail_d[c]                  = 1'b0;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            ch_q     <= '0;
            trim_q   <= {CHANNELS{MID}};
            cal_en_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rail_q   <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            ch_q     <= ch_d;
            trim_q   <= trim_d;
            cal_en_q <= cal_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rail_q   <= rail_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
        end
    end

    assign trim   = trim_q;
    assign cal_en = cal_en_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign rail   = rail_q;
    assign ch_idx = ch_q;

endmodule

// File: tb/tb_digiota_trim_cal.sv
// Self-checking bench for digiota_trim_cal: cycle-level reference model built from the
// SAR timeline arithmetic, randomized sequences, and a CHANNELS=3/TRIM_W=8/SETTLE=3 instance.
module tb_digiota_trim_cal;

    localparam int CH     = 2;
    localparam int W      = 5;
    localparam int ST     = 15;
    localparam int P      = ST + 1;
    localparam int PER_CH = W * P;
    localparam int TOTAL  = CH * PER_CH;
    localparam int MIDV   = 1 << (W - 1);
    localparam int LIMIT  = 2000;

    localparam int SCH = 3;
    localparam int SW  = 8;
    localparam int SST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CH-1:0]     cmp;
    logic [CH*W-1:0]   trim;
    logic [CH-1:0]     cal_en;
    logic              busy;
    logic              done;
    logic [CH-1:0]     rail;
    logic [2:0]        ch_idx;

    logic              start_s = 1'b0;
    logic              abort_s = 1'b0;
    logic [SCH-1:0]    cmp_s;
    logic [SCH*SW-1:0] trim_s;
    logic [SCH-1:0]    cal_en_s;
    logic              busy_s;
    logic              done_s;
    logic [SCH-1:0]    rail_s;
    logic [2:0]        ch_idx_s;

    int tgt[CH];
    int tgt_s[SCH];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    digiota_trim_cal #(.CHANNELS(CH), .TRIM_W(W), .SETTLE(ST)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cmp(cmp),
        .trim(trim), .cal_en(cal_en), .busy(busy), .done(done), .rail(rail), .ch_idx(ch_idx)
    );

    digiota_trim_cal #(.CHANNELS(SCH), .TRIM_W(SW), .SETTLE(SST)) u_sweep (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .cmp(cmp_s),
        .trim(trim_s), .cal_en(cal_en_s), .busy(busy_s), .done(done_s), .rail(rail_s), .ch_idx(ch_idx_s)
    );

    // Comparator model: output above reference when the code exceeds the target
    always_comb begin
        for (int c = 0; c < CH; c++) cmp[c] = (int'(trim[c*W +: W]) > tgt[c]);
        for (int c = 0; c < SCH; c++) cmp_s[c] = (int'(trim_s[c*SW +: SW]) > tgt_s[c]);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // SAR trial code while bit b is under test: target bits above b, then a 1 at b
    function automatic int trial(input int t, input int b);
        return (t & ~((1 << (b + 1)) - 1)) | (1 << b);
    endfunction

    function automatic bit is_rail(input int v, input int w);
        return (v == 0) || (v == (1 << w) - 1);
    endfunction

    // Reference model state
    bit m_active;
    int m_i;
    int m_code[CH];
    bit m_rail[CH];
    bit m_done;
    int m_tgt[CH];

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_i = 0;
            m_done = 1'b0;
            for (int c = 0; c < CH; c++) begin m_code[c] = MIDV; m_rail[c] = 1'b0; end
        end else if (m_active && abort) begin
            int ch;
            ch = m_i / PER_CH;
            for (int c = 0; c < ch; c++) begin m_code[c] = m_tgt[c]; m_rail[c] = is_rail(m_tgt[c], W); end
            m_code[ch] = MIDV;
            m_rail[ch] = 1'b0;
            m_active = 1'b0;
            m_done = 1'b0;
        end else if (m_active) begin
            m_i++;
            m_done = 1'b0;
            if (m_i == TOTAL) begin
                m_active = 1'b0;
                m_done = 1'b1;
                for (int c = 0; c < CH; c++) begin m_code[c] = m_tgt[c]; m_rail[c] = is_rail(m_tgt[c], W); end
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_active = 1'b1;
                m_i = 0;
                for (int c = 0; c < CH; c++) m_tgt[c] = tgt[c];
            end
        end
    end

    // Every-cycle compare of the default instance against the model
    always @(negedge clk) begin
        if (chk_en) begin : cmp_blk
            logic [CH*W-1:0] e_trim;
            logic [CH-1:0]   e_rail;
            logic [CH-1:0]   e_cal;
            logic [2:0]      e_idx;
            int ch;
            int b;
            e_cal = '0;
            e_idx = '0;
            if (m_active) begin
                ch = m_i / PER_CH;
                b = W - 1 - (m_i % PER_CH) / P;
                e_cal[ch] = 1'b1;
                e_idx = 3'(ch);
                for (int c = 0; c < CH; c++) begin
                    if (c < ch) begin
                        e_trim[c*W +: W] = W'(m_tgt[c]);
                        e_rail[c] = is_rail(m_tgt[c], W);
                    end else if (c == ch) begin
                        e_trim[c*W +: W] = W'(trial(m_tgt[c], b));
                        e_rail[c] = 1'b0;
                    end else begin
                        e_trim[c*W +: W] = W'(m_code[c]);
                        e_rail[c] = m_rail[c];
                    end
                end
            end else begin
                for (int c = 0; c < CH; c++) begin
                    e_trim[c*W +: W] = W'(m_code[c]);
                    e_rail[c] = m_rail[c];
                end
            end
            chk("model_trim", 64'(trim), 64'(e_trim));
            chk("model_busy", 64'(busy), 64'(m_active));
            chk("model_done", 64'(done), 64'(m_done));
            chk("model_cal_en", 64'(cal_en), 64'(e_cal));
            chk("model_rail", 64'(rail), 64'(e_rail));
            chk("model_ch_idx", 64'(ch_idx), 64'(e_idx));
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Count busy / done / channel-0 cycles from the current negedge until idle
    task automatic wait_idle(output int bc, output int dc, output int c0, output int c1);
        int k;
        bc = 0; dc = 0; c0 = 0; c1 = 0; k = 0;
        while (busy === 1'b1 && k < LIMIT) begin
            bc++;
            if (done === 1'b1) dc++;
            if (cal_en == 2'b01) c0++;
            if (cal_en == 2'b10) c1++;
            @(negedge clk);
            k++;
        end
        if (k >= LIMIT) chk("wait_idle_timeout", 64'(k), 64'(0));
        if (done === 1'b1) dc++;
        @(negedge clk);
        if (done === 1'b1) dc++;
    endtask

    initial begin
        int bc, dc, c0, c1, mode, k;
        tgt[0] = 16; tgt[1] = 16;
        tgt_s[0] = 0; tgt_s[1] = 0; tgt_s[2] = 0;

        // Reset for 2 cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_trim", 64'(trim), 64'({5'd16, 5'd16}));
        chk("reset_busy_done", 64'({busy, done}), 64'(0));
        chk("reset_cal_rail_idx", 64'({cal_en, rail, ch_idx}), 64'(0));
        rst = 1'b0;

        // Normal run
        tgt[0] = 19; tgt[1] = 7;
        pulse_start();
        wait_idle(bc, dc, c0, c1);
        chk("normal_busy_cycles", 64'(bc), 64'(160));
        chk("normal_cal_en0_cycles", 64'(c0), 64'(80));
        chk("normal_cal_en1_cycles", 64'(c1), 64'(80));
        chk("normal_done_count", 64'(dc), 64'(1));
        chk("normal_trim", 64'(trim), 64'({5'd7, 5'd19}));
        chk("normal_rail", 64'(rail), 64'(2'b00));

        // Rails, then a rerun that clears them
        tgt[0] = 0; tgt[1] = 31;
        pulse_start();
        wait_idle(bc, dc, c0, c1);
        chk("rails_trim", 64'(trim), 64'({5'd31, 5'd0}));
        chk("rails_rail", 64'(rail), 64'(2'b11));
        tgt[0] = 5; tgt[1] = 5;
        pulse_start();
        wait_idle(bc, dc, c0, c1);
        chk("rerun_trim", 64'(trim), 64'({5'd5, 5'd5}));
        chk("rerun_rail", 64'(rail), 64'(2'b00));

        // Abort at cycle 100 of busy
        tgt[0] = 19; tgt[1] = 7;
        pulse_start();
        repeat (100) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_trim", 64'(trim), 64'({5'd16, 5'd19}));
        chk("abort_cal_en", 64'(cal_en), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        @(negedge clk);
        chk("abort_done_late", 64'(done), 64'(0));

        // Start while busy is ignored
        pulse_start();
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(bc, dc, c0, c1);
        chk("start_busy_total", 64'(41 + bc), 64'(160));
        chk("start_busy_done", 64'(dc), 64'(1));

        // Start in the done cycle begins a new sequence
        tgt[0] = 3; tgt[1] = 28;
        pulse_start();
        k = 0;
        while (busy === 1'b1 && k < LIMIT) begin @(negedge clk); k++; end
        chk("done_cycle_seen", 64'(done), 64'(1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_cycle_restart", 64'(busy), 64'(1));
        wait_idle(bc, dc, c0, c1);
        chk("done_cycle_busy", 64'(bc), 64'(160));

        // Start and abort together in IDLE: start wins
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 64'(busy), 64'(1));
        wait_idle(bc, dc, c0, c1);

        // Reset mid-sequence
        pulse_start();
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_trim", 64'(trim), 64'({5'd16, 5'd16}));
        chk("midreset_busy", 64'(busy), 64'(0));

        // Randomized sequences
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < CH; c++) tgt[c] = int'($urandom_range(0, 31));
            @(negedge clk);
            start = 1'b1;
            abort = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                repeat ($urandom_range(1, 158)) @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end else if (mode == 1) begin
                repeat ($urandom_range(1, 158)) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end else if (mode == 2) begin
                repeat ($urandom_range(1, 150)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            wait_idle(bc, dc, c0, c1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Parameter sweep instance
        tgt_s[0] = 200; tgt_s[1] = 1; tgt_s[2] = 128;
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        bc = 0; dc = 0; k = 0;
        while (busy_s === 1'b1 && k < LIMIT) begin
            bc++;
            if (done_s === 1'b1) dc++;
            @(negedge clk);
            k++;
        end
        if (done_s === 1'b1) dc++;
        chk("sweep_busy_cycles", 64'(bc), 64'(96));
        chk("sweep_done", 64'(dc), 64'(1));
        chk("sweep_trim", 64'(trim_s), 64'({8'd128, 8'd1, 8'd200}));
        chk("sweep_rail", 64'(rail_s), 64'(3'b000));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
